plane_move_ctrl: RTL and testbench

- Consumer end of the button encoder interface.
- Takes the encoded move request (move_en + 2-bit direction) and turns it into the player plane's registered X/Y position.
- Press timing: one immediate step on press, a hold delay, then auto-repeat.
- Position is bounded to the playfield and sits between the button encoder and the renderer/collision logic.

---
 rtl/plane_move_ctrl_pkg.sv | 25 ++
 rtl/plane_axis_step.sv | 59 +++++
 rtl/plane_move_ctrl.sv | 152 +++++++++++++++
 tb/tb_plane_move_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/plane_move_ctrl_pkg.sv
// Shared definitions for the plane movement controller: direction codes from the
// button encoder, the FSM state encoding and a counter-width helper.
package plane_move_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    PM_IDLE   = 2'd0,
    PM_DELAY  = 2'd1,
    PM_REPEAT = 2'd2
  } pm_state_e;

  // Counter only ever holds values up to max(hold, repeat) - 1.
  function automatic int cnt_width(input int hold_cyc, input int rpt_cyc);
    int m;
    m = (hold_cyc > rpt_cyc) ? hold_cyc : rpt_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/plane_axis_step.sv
// One-axis +/-STEP position update. Saturates at 0/MAX by default; with
// PLANE_WRAP_EN defined the axis wraps around modulo MAX+1 and never clamps.
module plane_axis_step #(
  parameter int W    = 10,
  parameter int MAX  = 639,
  parameter int STEP = 4
) (
  input  logic [W-1:0] pos_i,
  input  logic         inc_i,
  output logic [W-1:0] pos_o,
  output logic         clamped_o
);

  localparam logic [W:0] MAX_E  = (W+1)'(MAX);
  localparam logic [W:0] STEP_E = (W+1)'(STEP);
  localparam logic [W:0] WRAP_E = (W+1)'(MAX + 1);
  localparam logic [W:0] TOP_E  = (W+1)'(MAX - STEP);

  logic [W:0] ext_s;
  logic [W:0] res_s;

  // Extended-width arithmetic so x+STEP and the compares cannot overflow.
  always_comb begin
    ext_s = {1'b0, pos_i};
    res_s = ext_s;
    if (inc_i) begin
`ifdef PLANE_WRAP_EN
      if (ext_s + STEP_E > MAX_E) begin
        res_s = ext_s + STEP_E - WRAP_E;
      end else begin
        res_s = ext_s + STEP_E;
      end
`else
      if (ext_s > TOP_E) begin
        res_s = MAX_E;
      end else begin
        res_s = ext_s + STEP_E;
      end
`endif
    end else begin
      if (ext_s < STEP_E) begin
`ifdef PLANE_WRAP_EN
        res_s = ext_s + WRAP_E - STEP_E;
`else
        res_s = '0;
`endif
      end else begin
        res_s = ext_s - STEP_E;
      end
    end
    pos_o = res_s[W-1:0];
`ifdef PLANE_WRAP_EN
    clamped_o = 1'b0;
`else
    clamped_o = (res_s == ext_s);
`endif
  end

endmodule

// File: rtl/plane_move_ctrl.sv
// Player plane position controller: registered move request in, immediate step on
// press, hold delay, then auto-repeat. PLANE_WRAP_EN selects a wrapping playfield.
module plane_move_ctrl
  import plane_move_ctrl_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 400,
  parameter int STEP     = 4,
  parameter int HOLD_CYC = 5000000,
  parameter int RPT_CYC  = 500000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           move_en_i,
  input  logic [1:0]     direct_i,
  output logic [X_W-1:0] pos_x_o,
  output logic [Y_W-1:0] pos_y_o,
  output logic           moving_o,
  output logic           step_o,
  output logic           blocked_o
);

  localparam int CNT_W = cnt_width(HOLD_CYC, RPT_CYC);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);

  logic             en_q;
  logic [1:0]       dir_q, last_dir_q, last_dir_d;
  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   pos_x_q, pos_x_d, x_nxt_s;
  logic [Y_W-1:0]   pos_y_q, pos_y_d, y_nxt_s;
  logic             moving_q, step_q, step_d, blocked_q, blocked_d;
  logic             do_step_s, x_clamp_s, y_clamp_s, is_x_s;

  plane_axis_step #(.W(X_W), .MAX(X_MAX), .STEP(STEP)) u_axis_x (
    .pos_i     (pos_x_q),
    .inc_i     (dir_q == DIR_RIGHT),
    .pos_o     (x_nxt_s),
    .clamped_o (x_clamp_s)
  );

  plane_axis_step #(.W(Y_W), .MAX(Y_MAX), .STEP(STEP)) u_axis_y (
    .pos_i     (pos_y_q),
    .inc_i     (dir_q == DIR_DOWN),
    .pos_o     (y_nxt_s),
    .clamped_o (y_clamp_s)
  );

  assign is_x_s = (dir_q == DIR_LEFT) || (dir_q == DIR_RIGHT);

  // Press/hold/repeat sequencing; a direction change while held counts as a new press.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dir_d = last_dir_q;
    do_step_s  = 1'b0;
    case (state_q)
      PM_IDLE: begin
        if (en_q) begin
          do_step_s  = 1'b1;
          cnt_d      = '0;
          state_d    = PM_DELAY;
          last_dir_d = dir_q;
        end else begin
          cnt_d = '0;
        end
      end
      PM_DELAY, PM_REPEAT: begin
        if (!en_q) begin
          state_d = PM_IDLE;
          cnt_d   = '0;
        end else if (dir_q != last_dir_q) begin
          do_step_s  = 1'b1;
          cnt_d      = '0;
          state_d    = PM_DELAY;
          last_dir_d = dir_q;
        end else if (cnt_q == ((state_q == PM_DELAY) ? HOLD_LAST : RPT_LAST)) begin
          do_step_s = 1'b1;
          cnt_d     = '0;
          state_d   = PM_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = PM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Apply a step to the selected axis and classify it as moved or blocked.
  always_comb begin
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    step_d    = 1'b0;
    blocked_d = 1'b0;
    if (do_step_s) begin
      if (is_x_s) begin
        pos_x_d   = x_nxt_s;
        step_d    = ~x_clamp_s;
        blocked_d = x_clamp_s;
      end else begin
        pos_y_d   = y_nxt_s;
        step_d    = ~y_clamp_s;
        blocked_d = y_clamp_s;
      end
    end else begin
      step_d    = 1'b0;
      blocked_d = 1'b0;
    end
  end

  // State, input stage and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      dir_q      <= 2'd0;
      last_dir_q <= 2'd0;
      state_q    <= PM_IDLE;
      cnt_q      <= '0;
      pos_x_q    <= X_W'(X_INIT);
      pos_y_q    <= Y_W'(Y_INIT);
      moving_q   <= 1'b0;
      step_q     <= 1'b0;
      blocked_q  <= 1'b0;
    end else begin
      en_q       <= move_en_i;
      dir_q      <= direct_i;
      last_dir_q <= last_dir_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      moving_q   <= (state_d != PM_IDLE);
      step_q     <= step_d;
      blocked_q  <= blocked_d;
    end
  end

  assign pos_x_o   = pos_x_q;
  assign pos_y_o   = pos_y_q;
  assign moving_o  = moving_q;
  assign step_o    = step_q;
  assign blocked_o = blocked_q;

endmodule

// File: tb/tb_plane_move_ctrl.sv
// Directed bench for plane_move_ctrl with a small playfield (0..9, STEP=2,
// HOLD_CYC=4, RPT_CYC=2). Inputs change and outputs are sampled on the falling edge.
module tb_plane_move_ctrl;
  import plane_move_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       move_en;
  logic [1:0] dir;
  logic [9:0] pos_x, pos_y;
  logic       moving, step, blocked;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  plane_move_ctrl #(
    .X_W(10), .Y_W(10), .X_MAX(9), .Y_MAX(9), .X_INIT(4), .Y_INIT(4),
    .STEP(2), .HOLD_CYC(4), .RPT_CYC(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .move_en_i (move_en),
    .direct_i  (dir),
    .pos_x_o   (pos_x),
    .pos_y_o   (pos_y),
    .moving_o  (moving),
    .step_o    (step),
    .blocked_o (blocked)
  );

  task automatic do_reset();
    rst     = 1'b1;
    move_en = 1'b0;
    dir     = DIR_UP;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pos_x !== 10'd4) begin n_err++; $display("FAIL reset_x: got %0d want 4", pos_x); end
    n_cmp++; if (pos_y !== 10'd4) begin n_err++; $display("FAIL reset_y: got %0d want 4", pos_y); end
    n_cmp++; if (moving !== 1'b0) begin n_err++; $display("FAIL reset_moving: got %b want 0", moving); end
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL reset_step: got %b want 0", step); end
    n_cmp++; if (blocked !== 1'b0) begin n_err++; $display("FAIL reset_blocked: got %b want 0", blocked); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (step !== 1'b0 || moving !== 1'b0) begin
        n_err++; $display("FAIL idle_quiet[%0d]: got step=%b moving=%b want 0/0", i, step, moving);
      end
    end
    n_cmp++; if (pos_x !== 10'd4 || pos_y !== 10'd4) begin
      n_err++; $display("FAIL idle_pos: got (%0d,%0d) want (4,4)", pos_x, pos_y);
    end
  endtask

  task automatic test_right_clamp();
    logic [9:0] exp_x [12] = '{10'd4, 10'd6, 10'd6, 10'd6, 10'd6, 10'd8,
                               10'd8, 10'd9, 10'd9, 10'd9, 10'd9, 10'd9};
    logic       exp_s [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_b [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    move_en = 1'b1;
    dir     = DIR_RIGHT;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++; if (pos_x !== exp_x[i] || step !== exp_s[i] || blocked !== exp_b[i]) begin
        n_err++;
        $display("FAIL right_hold[%0d]: got x=%0d step=%b blk=%b want x=%0d step=%b blk=%b",
                 i, pos_x, step, blocked, exp_x[i], exp_s[i], exp_b[i]);
      end
    end
    n_cmp++; if (moving !== 1'b1) begin n_err++; $display("FAIL right_moving: got %b want 1", moving); end
    move_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (moving !== 1'b0 || pos_x !== 10'd9) begin
      n_err++; $display("FAIL right_release: got moving=%b x=%0d want 0/9", moving, pos_x);
    end
  endtask

  task automatic test_left_pulses();
`ifdef PLANE_WRAP_EN
    logic [9:0] exp_x [3] = '{10'd2, 10'd0, 10'd8};
    logic       exp_s [3] = '{1'b1, 1'b1, 1'b1};
    logic       exp_b [3] = '{1'b0, 1'b0, 1'b0};
`else
    logic [9:0] exp_x [3] = '{10'd2, 10'd0, 10'd0};
    logic       exp_s [3] = '{1'b1, 1'b1, 1'b0};
    logic       exp_b [3] = '{1'b0, 1'b0, 1'b1};
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      move_en = 1'b1;
      dir     = DIR_LEFT;
      @(negedge clk);
      move_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (pos_x !== exp_x[i] || step !== exp_s[i] || blocked !== exp_b[i]) begin
        n_err++;
        $display("FAIL left_pulse[%0d]: got x=%0d step=%b blk=%b want x=%0d step=%b blk=%b",
                 i, pos_x, step, blocked, exp_x[i], exp_s[i], exp_b[i]);
      end
      repeat (2) @(negedge clk);
    end
    n_cmp++; if (moving !== 1'b0) begin n_err++; $display("FAIL left_idle: got moving=%b want 0", moving); end
`ifdef PLANE_WRAP_EN
    move_en = 1'b1;
    dir     = DIR_RIGHT;
    @(negedge clk);
    move_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (pos_x !== 10'd0 || step !== 1'b1 || blocked !== 1'b0) begin
      n_err++; $display("FAIL wrap_right: got x=%0d step=%b blk=%b want 0/1/0", pos_x, step, blocked);
    end
    repeat (2) @(negedge clk);
`endif
  endtask

  task automatic test_dir_change();
    logic [9:0] exp_y [6] = '{10'd2, 10'd4, 10'd4, 10'd4, 10'd4, 10'd6};
    logic       exp_s [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    move_en = 1'b1;
    dir     = DIR_UP;
    @(negedge clk);
    n_cmp++; if (pos_y !== 10'd4) begin n_err++; $display("FAIL up_latency: got y=%0d want 4", pos_y); end
    @(negedge clk);
    n_cmp++; if (pos_y !== 10'd2 || step !== 1'b1) begin
      n_err++; $display("FAIL up_step: got y=%0d step=%b want 2/1", pos_y, step);
    end
    @(negedge clk);
    dir = DIR_DOWN;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (pos_y !== exp_y[i] || step !== exp_s[i]) begin
        n_err++;
        $display("FAIL dir_change[%0d]: got y=%0d step=%b want y=%0d step=%b",
                 i, pos_y, step, exp_y[i], exp_s[i]);
      end
    end
    n_cmp++; if (pos_x !== 10'd4) begin n_err++; $display("FAIL dir_change_x: got x=%0d want 4", pos_x); end
    move_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    move_en = 1'b1;
    dir     = DIR_RIGHT;
    repeat (7) @(negedge clk);
    n_cmp++; if (pos_x !== 10'd8 || moving !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: got x=%0d moving=%b want 8/1", pos_x, moving);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (pos_x !== 10'd4 || pos_y !== 10'd4 || moving !== 1'b0 || step !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got (%0d,%0d) moving=%b step=%b want (4,4) 0 0",
                        pos_x, pos_y, moving, step);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (pos_x !== 10'd4) begin n_err++; $display("FAIL post_reset_wait: got x=%0d want 4", pos_x); end
    @(negedge clk);
    n_cmp++; if (pos_x !== 10'd6 || step !== 1'b1) begin
      n_err++; $display("FAIL post_reset_step: got x=%0d step=%b want 6/1", pos_x, step);
    end
    move_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifndef PLANE_WRAP_EN
    test_right_clamp();
`endif
    test_left_pulses();
    test_dir_change();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
